dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter for the single data memory (`dmem_sim`), placed between the memory stage and the memory. It shares that memory with a debug/loader port.
- The CPU has priority. A starvation guard guarantees debug access within a bounded number of cycles.
- At most one access is issued per cycle.
- Read data comes back one cycle after the grant. A registered valid is routed to the requester that issued the read.
- `out_stall` tells the pipeline that its access was not issued this cycle.

## Interface
- `ADDR_WIDTH`, default 12: data memory address width.
- `WORD_WIDTH`, default 16: data memory word width.
- `MAX_WAIT`, default 4: number of consecutive denied debug cycles after which debug wins. Legal range is 1..15.

Ports:
- `clock` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_cpu_req` input 1: CPU access request, from the memory stage.
- `in_cpu_we` input 1: CPU request is a write (1) or a read (0).
- `in_cpu_addr` input ADDR_WIDTH: CPU address.
- `in_cpu_wdata` input WORD_WIDTH: CPU write data.
- `out_cpu_gnt` output 1: CPU access issued this cycle (combinational).
- `out_cpu_rvalid` output 1: CPU read data valid this cycle (registered).
- `out_stall` output 1: equals `in_cpu_req & ~out_cpu_gnt`.
- `in_dbg_req` input 1: debug access request.
- `in_dbg_we` input 1: debug request is a write (1) or a read (0).
- `in_dbg_addr` input ADDR_WIDTH: debug address.
- `in_dbg_wdata` input WORD_WIDTH: debug write data.
- `out_dbg_gnt` output 1: debug access issued this cycle (combinational).
- `out_dbg_rvalid` output 1: debug read data valid this cycle (registered).
- `out_rdata` output WORD_WIDTH: passthrough of `in_mem_rd_word`, shared by both requesters.
- `out_mem_rd_addr` output ADDR_WIDTH: read address to memory.
- `out_mem_wr_addr` output ADDR_WIDTH: write address to memory.
- `out_mem_wr_word` output WORD_WIDTH: write data to memory.
- `out_mem_write_en` output 1: memory write strobe.
- `in_mem_rd_word` input WORD_WIDTH: memory read data, valid one cycle after the address.

## Operation
Grant selection (combinational, evaluated every cycle):
- Debug wins when `in_dbg_req` is high and either `in_cpu_req` is low or `wait_cnt == MAX_WAIT`.
- Otherwise the CPU wins when `in_cpu_req` is high.
- No request means no grant.
- `out_cpu_gnt` and `out_dbg_gnt` are never high together.

Memory drive:
- The granted requester's address drives both `out_mem_rd_addr` and `out_mem_wr_addr`.
- `out_mem_wr_word` carries the granted requester's write data.
- `out_mem_write_en = gnt & we` of the granted requester.
- With no grant, addresses and data are 0 and `write_en` is 0.

Owner register `owner_q` holds one of three states: NONE, CPU, DBG.
- On a clock edge with a granted read, `owner_q` takes that requester.
- Writes and idle cycles set it to NONE.
- `out_cpu_rvalid = (owner_q == CPU)` and `out_dbg_rvalid = (owner_q == DBG)`.

Starvation counter `wait_cnt` (4 bits):
- Increments when `in_dbg_req & ~out_dbg_gnt`, saturating at `MAX_WAIT`.
- Clears to 0 on a debug grant or when `in_dbg_req` is low.

Boundary cases:
- Both requests held: the CPU is granted `MAX_WAIT` times, then debug once, and the cycle repeats.
- A requester that drops its request without a grant loses nothing. No request is queued; requesters hold req/addr/data until granted.
- A write and a read in the same cycle are impossible, because only one access is issued.
- Two reads from different requesters in consecutive cycles each get their own rvalid pulse. `out_rdata` is correct for whichever rvalid is high.

## Timing
- Grant and memory drive are combinational from the requests and `wait_cnt`, with zero latency.
- Read latency: rvalid is asserted exactly 1 cycle after the grant, for 1 cycle.
- Write completes at the grant edge.
- Throughput is one access per cycle.
- While `reset` is high, asynchronously: `owner_q` = NONE, `wait_cnt` = 0, both rvalid = 0, and both grants, `out_stall` and `out_mem_write_en` are forced to 0.
- Reset mid-read: the pending rvalid is dropped.
- First possible grant is the cycle after `reset` deasserts.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined: `wait_cnt` and the `MAX_WAIT` override are present, as described above.
- Not defined: `wait_cnt` is removed and the CPU has strict priority. Debug is granted only in cycles with `in_cpu_req = 0`. `MAX_WAIT` is ignored.

## Test plan
- Reset: assert `reset` mid-cycle with a CPU read granted. Required: all outputs 0 immediately, and no rvalid after release.
- CPU write then read: write addr 0x010 data 0xBEEF, next cycle read 0x010. Required: `write_en` 1 for exactly one cycle, `out_cpu_rvalid` 1 the following cycle, `out_rdata` = 0xBEEF, `out_stall` 0 throughout.
- Debug alone: debug write 0x7FF = 0x1234, then debug read. Required: debug gnt each cycle, `out_dbg_rvalid` with 0x1234, `out_cpu_rvalid` stays 0.
- Contention with guard, `MAX_WAIT` = 4: both requests held for 10 cycles. Required grant pattern: C C C C D C C C C D; `out_stall` high in cycles 5 and 10.
- Contention without the macro: same stimulus. Required: CPU granted all 10 cycles, debug granted in cycle 11 after the CPU drops its request.
- Back-to-back reads: CPU read 0x020 (holding 0xAAAA), then debug read 0x021 (holding 0x5555). Required: `out_cpu_rvalid` with 0xAAAA, then `out_dbg_rvalid` with 0x5555 on the next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, debug) arbiter for the single-ported data memory.
// Optional starvation guard for the debug port: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_cpu_req,
  input  logic                  in_cpu_we,
  input  logic [ADDR_WIDTH-1:0] in_cpu_addr,
  input  logic [WORD_WIDTH-1:0] in_cpu_wdata,
  output logic                  out_cpu_gnt,
  output logic                  out_cpu_rvalid,
  output logic                  out_stall,
  input  logic                  in_dbg_req,
  input  logic                  in_dbg_we,
  input  logic [ADDR_WIDTH-1:0] in_dbg_addr,
  input  logic [WORD_WIDTH-1:0] in_dbg_wdata,
  output logic                  out_dbg_gnt,
  output logic                  out_dbg_rvalid,
  output logic [WORD_WIDTH-1:0] out_rdata,
  output logic [ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_rd_word
);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnDbg  = 2'd2
  } owner_e;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gen_max_wait_check
    $error("MAX_WAIT must be in 1..15");
  end

  owner_e owner_q, owner_d;
  logic   cpu_gnt, dbg_gnt;
  logic   starve;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign starve = (wait_cnt_q == MaxWait);

  // Counts consecutive denied debug cycles; any gap in the request restarts it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!in_dbg_req || dbg_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are held low while reset is asserted so nothing reaches memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      if (in_dbg_req && (!in_cpu_req || starve)) begin
        dbg_gnt = 1'b1;
      end else if (in_cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    out_mem_rd_addr  = '0;
    out_mem_wr_addr  = '0;
    out_mem_wr_word  = '0;
    out_mem_write_en = 1'b0;
    owner_d          = OwnNone;
    if (cpu_gnt) begin
      out_mem_rd_addr  = in_cpu_addr;
      out_mem_wr_addr  = in_cpu_addr;
      out_mem_wr_word  = in_cpu_wdata;
      out_mem_write_en = in_cpu_we;
      owner_d          = in_cpu_we ? OwnNone : OwnCpu;
    end else if (dbg_gnt) begin
      out_mem_rd_addr  = in_dbg_addr;
      out_mem_wr_addr  = in_dbg_addr;
      out_mem_wr_word  = in_dbg_wdata;
      out_mem_write_en = in_dbg_we;
      owner_d          = in_dbg_we ? OwnNone : OwnDbg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OwnNone;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign out_cpu_gnt    = cpu_gnt;
  assign out_dbg_gnt    = dbg_gnt;
  assign out_stall      = in_cpu_req & ~cpu_gnt & ~reset;
  assign out_cpu_rvalid = (owner_q == OwnCpu);
  assign out_dbg_rvalid = (owner_q == OwnDbg);
  assign out_rdata      = in_mem_rd_word;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus random traffic against
// a transaction-level model (denied-streak count, pending-read record, shadow memory).
module tb_dmem_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned WW = 16;
  localparam int unsigned MW = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [WW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, stall, dbg_gnt, dbg_rvalid;
  logic [WW-1:0] rdata, mem_wr_word, mem_rd_word;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic          mem_we;

  dmem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_WAIT(MW)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_cpu_req      (cpu_req),
    .in_cpu_we       (cpu_we),
    .in_cpu_addr     (cpu_addr),
    .in_cpu_wdata    (cpu_wdata),
    .out_cpu_gnt     (cpu_gnt),
    .out_cpu_rvalid  (cpu_rvalid),
    .out_stall       (stall),
    .in_dbg_req      (dbg_req),
    .in_dbg_we       (dbg_we),
    .in_dbg_addr     (dbg_addr),
    .in_dbg_wdata    (dbg_wdata),
    .out_dbg_gnt     (dbg_gnt),
    .out_dbg_rvalid  (dbg_rvalid),
    .out_rdata       (rdata),
    .out_mem_rd_addr (mem_rd_addr),
    .out_mem_wr_addr (mem_wr_addr),
    .out_mem_wr_word (mem_wr_word),
    .out_mem_write_en(mem_we),
    .in_mem_rd_word  (mem_rd_word)
  );

  always #5 clock = ~clock;

  // Memory with a one-cycle registered read, like dmem_sim.
  logic [WW-1:0] mem [1 << AW];
  always @(posedge clock) begin
    if (mem_we) mem[mem_wr_addr] <= mem_wr_word;
    mem_rd_word <= mem[mem_rd_addr];
  end

  // Reference model state.
  logic [WW-1:0] ref_mem [1 << AW];
  int            denied;     // consecutive cycles debug asked and was refused
  int            pend_who;   // 0 none, 1 cpu, 2 dbg
  logic [WW-1:0] pend_data;
  int            n_checks, n_fail;
  string         gnt_log;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [WW-1:0] cd, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [WW-1:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  // One clock: drive at posedge+1, check at the following negedge, advance model.
  task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [WW-1:0] cd, input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [WW-1:0] dd);
    bit e_dbg, e_cpu, e_we;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_data;
    drive(cr, cw, ca, cd, dr, dw, da, dd);
    #4;
    e_dbg  = dr && (!cr || (Guard && denied == int'(MW)));
    e_cpu  = cr && !e_dbg;
    e_we   = e_cpu ? cw : (e_dbg ? dw : 1'b0);
    e_addr = e_cpu ? ca : (e_dbg ? da : '0);
    e_data = e_cpu ? cd : (e_dbg ? dd : '0);
    check_eq("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
    check_eq("dbg_gnt", 32'(dbg_gnt), 32'(e_dbg));
    check_eq("stall", 32'(stall), 32'(cr && !e_cpu));
    check_eq("write_en", 32'(mem_we), 32'(e_we));
    check_eq("rd_addr", 32'(mem_rd_addr), 32'(e_addr));
    check_eq("wr_addr", 32'(mem_wr_addr), 32'(e_addr));
    check_eq("wr_word", 32'(mem_wr_word), 32'(e_data));
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_who == 1));
    check_eq("dbg_rvalid", 32'(dbg_rvalid), 32'(pend_who == 2));
    if (pend_who != 0) check_eq("rdata", 32'(rdata), 32'(pend_data));
    gnt_log = {gnt_log, e_cpu ? "C" : (e_dbg ? "D" : "-")};
    pend_who = 0;
    if ((e_cpu || e_dbg) && !e_we) begin
      pend_who  = e_cpu ? 1 : 2;
      pend_data = ref_mem[e_addr];
    end
    if (e_we) ref_mem[e_addr] = e_data;
    if (dr && !e_dbg) denied = (denied < int'(MW)) ? denied + 1 : denied;
    else denied = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; denied = 0; pend_who = 0; pend_data = '0; gnt_log = "";
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check_eq("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    reset = 1'b0;
    idle();

    // CPU write then read of the same word.
    step(1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, '0, '0);
    idle();
    check_eq("cpu_rd_beef", 32'(ref_mem[12'h010]), 32'h0000_BEEF);

    // Debug alone: write then read back.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h7FF, 16'h1234);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h7FF, 16'h0000);
    idle();

    // Back-to-back reads from different requesters.
    step(1'b1, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h021, 16'h5555);
    step(1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h021, 16'h0000);
    idle();

    // Contention: both held 10 cycles, then the CPU drops.
    idle();
    gnt_log = "";
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 12'h030, '0, 1'b1, 1'b0, 12'h031, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h031, '0);
    if (Guard) check_eq("contend_pattern", 32'(gnt_log == "CCCCDCCCCDD"), 32'd1);
    else check_eq("contend_pattern", 32'(gnt_log == "CCCCCCCCCCD"), 32'd1);
    idle();

    // Reset asserted mid-cycle while a CPU read is granted.
    drive(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b1, 12'h011, 16'h7777);
    #4;
    reset = 1'b1;
    #1;
    check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_eq("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_write_en", 32'(mem_we), 32'd0);
    check_eq("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    pend_who = 0;
    denied = 0;
    idle();
    idle();

    // Random traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom), AW'($urandom_range(0, 15)),
           WW'($urandom), 1'($urandom_range(0, 99) < 50), 1'($urandom),
           AW'($urandom_range(0, 15)), WW'($urandom));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
